stopwatch_tx_report: RTL and testbench
======================================

STOPWATCH_TX_REPORT -- requirements
Module: stopwatch_tx_report

Interface
REQ-001 The block SHALL have parameter SEND_CRLF, default 1: 1 = append CR (8'h0D) and LF (8'h0A) after the digits; 0 = send digits only.
REQ-002 The block SHALL have parameter MAX_COUNT, default 9999: saturation limit for the latched count.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 count  input  14  binary stopwatch count (centiseconds) from the stopwatch counter.
REQ-006 req  input  1  single-cycle report request, e.g. from the stopwatch FSM on a UART command.
REQ-007 tx_full  input  1  full flag of the downstream TX FIFO.
REQ-008 tx_wr  output  1  TX FIFO write strobe, single-cycle per byte.
REQ-009 tx_data  output  8  ASCII byte, valid while tx_wr=1.
REQ-010 busy  output  1  high from request acceptance until frame completion.
REQ-011 done  output  1  single-cycle pulse when a frame completes.

Function
REQ-012 States SHALL be IDLE, CONV, SEND and FIN.
REQ-013 In IDLE, req=1 SHALL latch min(count, MAX_COUNT) on that edge, move to CONV, and set busy=1 on the next cycle.
REQ-014 req while busy=1 SHALL be ignored, with no queueing and no restart.
REQ-015 CONV SHALL run sequential double-dabble binary-to-BCD for exactly 14 cycles, producing four BCD digits (thousands, hundreds, tens, ones), then move to SEND.
REQ-016 Each BCD nibble SHALL become ASCII as 8'h30 + digit.
REQ-017 Leading zeros SHALL be kept, so every frame carries exactly 4 digits.
REQ-018 Byte order SHALL be thousands, hundreds, tens, ones, then CR and LF if SEND_CRLF=1.
REQ-019 Frame length SHALL be 6 bytes (SEND_CRLF=1) or 4 bytes (SEND_CRLF=0).
REQ-020 In SEND, a cycle with tx_full=0 SHALL assert tx_wr=1 with the current byte and advance the byte index.
REQ-021 In SEND, a cycle with tx_full=1 SHALL keep tx_wr=0 and hold the byte index (stall without loss or duplication).
REQ-022 Back-to-back writes on consecutive cycles SHALL be allowed while tx_full=0.
REQ-023 After the last byte is written, the block SHALL enter FIN for one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-024 Latency with no stall: req at edge N, first tx_wr in cycle N+15, last tx_wr in cycle N+20 (SEND_CRLF=1), done in cycle N+21.
REQ-025 The latched value SHALL be frozen for the whole frame; changes on count after the latch SHALL NOT affect the frame.
REQ-026 If count exceeds MAX_COUNT (e.g. 14'h3FFF = 16383), the block SHALL send "9999".
REQ-027 tx_wr SHALL never be 1 while tx_full=1.
REQ-028 tx_wr SHALL never be 1 outside SEND.

Reset
REQ-029 reset=0 SHALL clear asynchronously, in any state including mid-frame, to: state IDLE, tx_wr=0, tx_data=8'h00, busy=0, done=0, latched value 0, BCD shifter 0, byte index 0.
REQ-030 A frame interrupted by reset SHALL NOT resume after reset is released.
REQ-031 The first req after reset release SHALL start a fresh frame.

Structure
REQ-032 A shared package SHALL hold the state encoding, ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, and the count width 14.
REQ-033 The double-dabble converter SHALL be one sub-module, bin2bcd_seq, with start/done handshake, 14-bit input and 16-bit BCD output.
REQ-034 The FSM, byte mux and write logic SHALL stay in the top module.

Verification
REQ-035 count=1234, req pulse, tx_full=0 -> bytes 31 32 33 34 0D 0A on consecutive cycles, first tx_wr at N+15, done at N+21.
REQ-036 count=7, SEND_CRLF=0 -> bytes 30 30 30 37, done one cycle after the last write, busy low afterwards.
REQ-037 count=12000 -> bytes 39 39 39 39 0D 0A (saturation).
REQ-038 count=0042; tx_full=1 for 3 cycles after the 2nd byte -> exactly 30 30 34 32 0D 0A with no duplicate or lost byte, and tx_wr=0 throughout the stall.
REQ-039 Second req and a count change to 5555 mid-frame (count=0100) -> only one frame, 30 31 30 30 0D 0A.
REQ-040 reset=0 during the 3rd byte -> all outputs 0 immediately; after release, req with count=9999 -> full frame 39 39 39 39 0D 0A.

Source files
------------

// File: rtl/stopwatch_tx_report_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_tx_report_pkg : shared constants, state encoding, BCD step helper
// Revision: 1.0
// ============================================================================
package stopwatch_tx_report_pkg;

    localparam int COUNT_W = 14;
    localparam int BCD_W   = 16;
    localparam int SH_W    = BCD_W + COUNT_W;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_SEND = 2'd2;
    localparam state_t ST_FIN  = 2'd3;

    // One double-dabble iteration over {bcd, bin}: add-3 on nibbles >= 5, then shift left.
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
        logic [SH_W-1:0] a;
        a = s;
        for (int k = 0; k < 4; k++) begin
            if (a[COUNT_W + 4*k +: 4] >= 4'd5) begin
                a[COUNT_W + 4*k +: 4] = a[COUNT_W + 4*k +: 4] + 4'd3;
            end
        end
        return {a[SH_W-2:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_tx_report_bin2bcd.sv
`default_nettype none
// ============================================================================
// bin2bcd_seq : sequential 14-bit binary to 4-digit BCD, one bit per cycle
// Revision: 1.0
// ============================================================================
module bin2bcd_seq
    import stopwatch_tx_report_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COUNT_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    logic [SH_W-1:0] r_sh;
    logic [3:0]      r_left;
    logic            r_run;
    logic            r_done;

    // The start cycle already performs the first of the COUNT_W iterations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh   <= '0;
            r_left <= 4'd0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_sh   <= dd_step({{BCD_W{1'b0}}, bin});
                r_left <= 4'(COUNT_W - 1);
                r_run  <= 1'b1;
            end else if (r_run) begin
                r_sh   <= dd_step(r_sh);
                r_left <= r_left - 4'd1;
                if (r_left == 4'd1) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bcd  = r_sh[SH_W-1 -: BCD_W];
    assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/stopwatch_tx_report.sv
`default_nettype none
// ============================================================================
// stopwatch_tx_report : latches a stopwatch count and sends it as ASCII digits
// Revision: 1.0
// ============================================================================
module stopwatch_tx_report
    import stopwatch_tx_report_pkg::*;
#(
    parameter int SEND_CRLF = 1,
    parameter int MAX_COUNT = 9999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count,
    input  logic               req,
    input  logic               tx_full,
    output logic               tx_wr,
    output logic [7:0]         tx_data,
    output logic               busy,
    output logic               done
);

    localparam logic [COUNT_W-1:0] C_MAX      = COUNT_W'(MAX_COUNT);
    localparam logic [2:0]         C_LAST_IDX = (SEND_CRLF != 0) ? 3'd5 : 3'd3;

    state_t             r_state;
    state_t             w_next;
    logic [COUNT_W-1:0] r_latched;
    logic [COUNT_W-1:0] w_sat;
    logic               r_start;
    logic [2:0]         r_idx;
    logic [BCD_W-1:0]   w_bcd;
    logic               w_conv_done;
    logic               w_accept;
    logic               w_push;
    logic [7:0]         w_byte;

    assign w_sat    = (count > C_MAX) ? C_MAX : count;
    assign w_accept = (r_state == ST_IDLE) && req;
    assign w_push   = (r_state == ST_SEND) && !tx_full;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (r_start),
        .bin   (r_latched),
        .bcd   (w_bcd),
        .done  (w_conv_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Converter is kicked one cycle after acceptance so it reads the frozen copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_latched <= '0;
            r_start   <= 1'b0;
            r_idx     <= 3'd0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_latched <= w_sat;
                r_idx     <= 3'd0;
            end else if (w_push) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (req)         w_next = ST_CONV;
            ST_CONV: if (w_conv_done) w_next = ST_SEND;
            ST_SEND: if (w_push && (r_idx == C_LAST_IDX)) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_byte = ASCII_ZERO;
        case (r_idx)
            3'd0:    w_byte = ASCII_ZERO + {4'h0, w_bcd[15:12]};
            3'd1:    w_byte = ASCII_ZERO + {4'h0, w_bcd[11:8]};
            3'd2:    w_byte = ASCII_ZERO + {4'h0, w_bcd[7:4]};
            3'd3:    w_byte = ASCII_ZERO + {4'h0, w_bcd[3:0]};
            3'd4:    w_byte = ASCII_CR;
            3'd5:    w_byte = ASCII_LF;
            default: w_byte = ASCII_ZERO;
        endcase
    end

    // Write strobe is combinational so it can never coincide with tx_full.
    always_comb begin
        tx_wr   = 1'b0;
        tx_data = 8'h00;
        busy    = (r_state != ST_IDLE);
        done    = (r_state == ST_FIN);
        if (w_push) begin
            tx_wr   = 1'b1;
            tx_data = w_byte;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_tx_report.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_tx_report : randomized frames vs. arithmetic reference model
// Revision: 1.0
// ============================================================================
module tb_stopwatch_tx_report;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] count = '0;
    logic        req = 1'b0;
    logic        tx_full = 1'b0;
    logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]  data_a, data_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         nwr[2];
    int         ndone[2];
    int         first[2];
    int         last[2];
    int         done_cyc[2];
    logic       prev_dn[2];
    logic [7:0] got[2][16];

    stopwatch_tx_report #(.SEND_CRLF(1), .MAX_COUNT(9999)) dut_a (
        .clk(clk), .reset(reset), .count(count), .req(req), .tx_full(tx_full),
        .tx_wr(wr_a), .tx_data(data_a), .busy(busy_a), .done(done_a));

    stopwatch_tx_report #(.SEND_CRLF(0), .MAX_COUNT(9999)) dut_b (
        .clk(clk), .reset(reset), .count(count), .req(req), .tx_full(tx_full),
        .tx_wr(wr_b), .tx_data(data_b), .busy(busy_b), .done(done_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic mon(input int i, input logic wr, input logic [7:0] d, input logic bz, input logic dn);
        if (tx_full) check_val("wr_while_full", 32'(wr), 32'd0);
        if (wr) begin
            check_val("wr_busy", 32'(bz), 32'd1);
            if (nwr[i] < 16) got[i][nwr[i]] = d;
            if (nwr[i] == 0) first[i] = cyc;
            last[i] = cyc;
            nwr[i]++;
        end
        if (dn) begin
            ndone[i]++;
            done_cyc[i] = cyc;
            check_val("fin_busy", 32'(bz), 32'd1);
        end
        if (prev_dn[i]) check_val("idle_after_fin", 32'(bz), 32'd0);
        prev_dn[i] = dn;
    endtask

    always @(negedge clk) begin
        mon(0, wr_a, data_a, busy_a, done_a);
        mon(1, wr_b, data_b, busy_b, done_b);
    end

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            nwr[i] = 0; ndone[i] = 0; first[i] = -1; last[i] = -1; done_cyc[i] = -1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_wr"},   32'({wr_a, wr_b}),     32'd0);
        check_val({tag, "_data"}, 32'({data_a, data_b}), 32'd0);
        check_val({tag, "_busy"}, 32'({busy_a, busy_b}), 32'd0);
        check_val({tag, "_done"}, 32'({done_a, done_b}), 32'd0);
    endtask

    // mode: 0 = never full, 1 = random full, 2 = full for 3 cycles after byte 2
    task automatic do_frame(input logic [13:0] v, input int mode, input bit mid, input int idle_after);
        int         n;
        int         stall_n;
        int         s;
        bit         fin;
        logic [7:0] exp_b[6];
        @(posedge clk); #1;
        clr();
        count = v; req = 1'b1; tx_full = 1'b0;
        n = cyc + 1;
        @(posedge clk); #1;
        req = 1'b0;
        if (!mid) count = 14'($urandom);
        @(negedge clk);
        check_val("busy_after_req", 32'({busy_a, busy_b}), 32'd3);
        stall_n = 0;
        fin = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (mid && cyc == n + 3) begin
                req = 1'b1; count = 14'd5555;
            end else if (!mid) begin
                count = 14'($urandom);
            end
            case (mode)
                1: tx_full = ($urandom_range(0, 2) == 0);
                2: if (nwr[0] >= 2 && stall_n < 3) begin tx_full = 1'b1; stall_n++; end
                   else tx_full = 1'b0;
                default: tx_full = 1'b0;
            endcase
            fin = (ndone[0] > 0) && (ndone[1] > 0);
        end
        check_val("frame_finished", 32'(fin), 32'd1);
        tx_full = 1'b0; req = 1'b0;
        repeat (idle_after) @(posedge clk);
        #1;

        s = (v > 14'd9999) ? 9999 : int'(v);
        exp_b[0] = 8'(48 + s / 1000);
        exp_b[1] = 8'(48 + (s / 100) % 10);
        exp_b[2] = 8'(48 + (s / 10) % 10);
        exp_b[3] = 8'(48 + s % 10);
        exp_b[4] = 8'h0D;
        exp_b[5] = 8'h0A;
        check_val("len_crlf", nwr[0], 6);
        check_val("len_nocrlf", nwr[1], 4);
        for (int j = 0; j < 6; j++)
            if (j < nwr[0]) check_val("byte_crlf", 32'(got[0][j]), 32'(exp_b[j]));
        for (int j = 0; j < 4; j++)
            if (j < nwr[1]) check_val("byte_nocrlf", 32'(got[1][j]), 32'(exp_b[j]));
        check_val("done_count_crlf", ndone[0], 1);
        check_val("done_count_nocrlf", ndone[1], 1);
        check_val("done_after_last_crlf", done_cyc[0], last[0] + 1);
        check_val("done_after_last_nocrlf", done_cyc[1], last[1] + 1);
        if (mode == 0) begin
            check_val("first_wr_crlf", first[0], n + 15);
            check_val("last_wr_crlf", last[0], n + 20);
            check_val("done_crlf", done_cyc[0], n + 21);
            check_val("first_wr_nocrlf", first[1], n + 15);
            check_val("done_nocrlf", done_cyc[1], n + 19);
        end
    endtask

    task automatic reset_mid_frame();
        bit hit;
        @(posedge clk); #1;
        clr();
        count = 14'd1234; req = 1'b1; tx_full = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (nwr[0] >= 2) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_val("reached_byte3", 32'(hit), 32'd1);
        check_val("bytes_before_reset", nwr[0], 2);
        check_val("byte3_in_flight", 32'(wr_a), 32'd1);
        #2 reset = 1'b0;
        #1 check_idle_outputs("async_reset");
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        clr();
        repeat (30) @(posedge clk);
        #1;
        check_val("no_resume", nwr[0] + nwr[1] + ndone[0] + ndone[1], 0);
    endtask

    initial begin
        clr();
        prev_dn[0] = 1'b0; prev_dn[1] = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("post_reset");

        do_frame(14'd1234, 0, 1'b0, 3);
        do_frame(14'd7, 0, 1'b0, 3);
        do_frame(14'd12000, 0, 1'b0, 3);
        do_frame(14'h3FFF, 0, 1'b0, 3);
        do_frame(14'd42, 2, 1'b0, 3);
        do_frame(14'd100, 0, 1'b1, 25);
        reset_mid_frame();
        do_frame(14'd9999, 0, 1'b0, 3);
        for (int r = 0; r < 10; r++) begin
            logic [13:0] v;
            int          mode;
            bit          mid;
            v    = 14'($urandom_range(0, 16383));
            mode = int'($urandom_range(0, 1));
            mid  = 1'($urandom_range(0, 1));
            do_frame(v, mode, mid, mid ? 25 : 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
